msrv32_lsu_ctrl: RTL and testbench
==================================

// Module: msrv32_lsu_ctrl
// PURPOSE
//  Stage-3 load/store controller; consumes the registered decode outputs (load_size, load_unsigned,
//  iadder, rs2, rd_addr). Runs one req/ack transaction per access on the data bus, realigns and
//  sign/zero-extends load data, and stalls the pipeline until the access completes.
// PARAMETERS
//  MAX_WAIT  255  cycles in WAIT without ack before abort; 0 = wait forever (counter 16 bit)
// PORTS
//  clk_in            in   1   clock; all state updates on posedge
//  reset_in          in   1   synchronous, active-high reset
//  ld_req_in         in   1   load request (sampled only in IDLE)
//  st_req_in         in   1   store request (sampled only in IDLE); wins over ld_req_in
//  load_size_in      in   2   00 byte, 01 half, 10/11 word
//  load_unsigned_in  in   1   1 = zero-extend load, 0 = sign-extend
//  addr_in           in   32  byte address (iadder result)
//  st_data_in        in   32  store data (rs2)
//  rd_addr_in        in   5   load destination register
//  dbus_addr_out     out  32  word address {addr[31:2],2'b00}
//  dbus_wdata_out    out  32  lane-replicated store data
//  dbus_wr_mask_out  out  4   byte-lane write strobes (0 for loads)
//  dbus_rd_req_out   out  1   read request, held until ack
//  dbus_wr_req_out   out  1   write request, held until ack
//  dbus_rdata_in     in   32  read data, valid with ack
//  dbus_ack_in       in   1   transaction complete
//  stall_out         out  1   freeze upstream pipeline
//  ld_data_out       out  32  extended load result
//  ld_valid_out      out  1   1-cycle pulse: ld_data_out/rd_addr_out valid
//  rd_addr_out       out  5   destination register of completed load
//  bus_err_out       out  1   1-cycle pulse on timeout abort
//  misaligned_out    out  1   1-cycle pulse on misaligned access (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, wait counter 0; reset mid-transaction aborts, no pulse emitted.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: stall_out = ld_req_in|st_req_in (combinational). On request capture addr/size/unsigned/
//   data/rd; next cycle WAIT with dbus_*_req_out, addr, mask, wdata registered and stable.
//  WAIT: stall_out=1; counter increments each cycle; on dbus_ack_in -> DONE, latch aligned rdata;
//   requests drop the cycle after ack. Counter reaching MAX_WAIT (!=0) without ack -> DONE w/ error.
//  DONE: stall_out=0; loads pulse ld_valid_out; timeout pulses bus_err_out (ld_valid_out=0).
//  Latency: request cycle 0, bus req cycle 1, ack cycle k>=1, ld_valid_out cycle k+1.
//  Ack in IDLE/DONE ignored; ack held multiple cycles counts once. Requests in WAIT/DONE ignored.
//  Store lanes: byte mask 4'b0001<<a[1:0], wdata {4{d[7:0]}}; half mask 4'b0011<<{a[1],1'b0},
//   wdata {2{d[15:0]}}; word mask 4'b1111, wdata d.
//  Load extract: byte lane a[1:0], half lane a[1], word whole; extend bit 7/15 unless unsigned.
// CONFIGURATION
//  MSRV32_MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 skips the bus,
//   IDLE->DONE directly, misaligned_out pulses in DONE, no ld_valid_out, stall 1 cycle only.
//  Undefined: low address bits beyond access size ignored (half uses a[1], word none), access
//   proceeds normally, misaligned_out constant 0.
// TESTING
//  LB addr 0x103, rdata 0x80_00_00_00, ack cycle 2 -> ld_data 0xFFFFFF80, ld_valid cycle 3.
//  LHU addr 0x102, rdata 0xBEEF_1234 -> ld_data 0x0000BEEF, rd_addr echoed.
//  SB addr 0x201 data 0x000000A5 -> mask 4'b0010, wdata 0xA5A5A5A5, dbus_addr 0x200.
//  LW, no ack, MAX_WAIT=4 -> bus_err_out pulse after 4 WAIT cycles, stall released, req dropped.
//  LW addr 0x102 with macro -> misaligned_out pulse, no dbus req; without -> read 0x100 normally.
//  reset_in asserted in WAIT -> next edge all outputs 0, IDLE; later ack ignored.

Source files
------------

// File: rtl/msrv32_lsu_ctrl.sv
// rtl/msrv32_lsu_ctrl.sv - stage-3 load/store controller: one req/ack data-bus access per load or store
// Optional feature macro: MSRV32_MISALIGN_TRAP_EN (misaligned half/word accesses skip the bus and pulse misaligned_out)
module msrv32_lsu_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        ld_req_in,
    input  logic        st_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] st_data_in,
    input  logic [4:0]  rd_addr_in,
    output logic [31:0] dbus_addr_out,
    output logic [31:0] dbus_wdata_out,
    output logic [3:0]  dbus_wr_mask_out,
    output logic        dbus_rd_req_out,
    output logic        dbus_wr_req_out,
    input  logic [31:0] dbus_rdata_in,
    input  logic        dbus_ack_in,
    output logic        stall_out,
    output logic [31:0] ld_data_out,
    output logic        ld_valid_out,
    output logic [4:0]  rd_addr_out,
    output logic        bus_err_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] MAX_WAIT_W = 16'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_req_q, wr_req_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        is_load_q, is_load_d;
    logic        err_q, err_d;
`ifdef MSRV32_MISALIGN_TRAP_EN
    logic        misal_q, misal_d;
    logic        misal_req;
`endif

    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Store lane strobes and replicated write data derived from the incoming request
    always_comb begin
        lane_mask  = 4'b1111;
        lane_wdata = st_data_in;
        case (load_size_in)
            2'b00: begin
                lane_mask  = 4'b0001 << addr_in[1:0];
                lane_wdata = {4{st_data_in[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011 << {addr_in[1], 1'b0};
                lane_wdata = {2{st_data_in[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = st_data_in;
            end
        endcase
    end

`ifdef MSRV32_MISALIGN_TRAP_EN
    // A half needs a[0]=0 and a word needs a[1:0]=0; bytes are always aligned
    always_comb begin
        misal_req = 1'b0;
        if (load_size_in == 2'b01) begin
            misal_req = addr_in[0];
        end else if (load_size_in[1]) begin
            misal_req = (addr_in[1:0] != 2'b00);
        end
    end
`endif

    // Pick the addressed byte/half out of the bus word and sign- or zero-extend it
    always_comb begin
        rd_byte = dbus_rdata_in[7:0];
        case (addr_q[1:0])
            2'b00:   rd_byte = dbus_rdata_in[7:0];
            2'b01:   rd_byte = dbus_rdata_in[15:8];
            2'b10:   rd_byte = dbus_rdata_in[23:16];
            default: rd_byte = dbus_rdata_in[31:24];
        endcase
        rd_half = addr_q[1] ? dbus_rdata_in[31:16] : dbus_rdata_in[15:0];
        case (size_q)
            2'b00:   rd_ext = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = dbus_rdata_in;
        endcase
    end

    // Next-state logic: capture in IDLE, wait for ack or timeout, one DONE cycle for pulses
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        rd_d      = rd_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        is_load_d = is_load_q;
        err_d     = err_q;
`ifdef MSRV32_MISALIGN_TRAP_EN
        misal_d   = misal_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_req_in || st_req_in) begin
                    addr_d    = addr_in;
                    size_d    = load_size_in;
                    uns_d     = load_unsigned_in;
                    rd_d      = rd_addr_in;
                    is_load_d = !st_req_in;
                    err_d     = 1'b0;
                    cnt_d     = 16'd0;
`ifdef MSRV32_MISALIGN_TRAP_EN
                    misal_d   = misal_req;
                    if (misal_req) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_WAIT;
                        rd_req_d = !st_req_in;
                        wr_req_d = st_req_in;
                        mask_d   = st_req_in ? lane_mask : 4'b0000;
                        wdata_d  = st_req_in ? lane_wdata : 32'd0;
                    end
`else
                    state_d  = S_WAIT;
                    rd_req_d = !st_req_in;
                    wr_req_d = st_req_in;
                    mask_d   = st_req_in ? lane_mask : 4'b0000;
                    wdata_d  = st_req_in ? lane_wdata : 32'd0;
`endif
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (dbus_ack_in) begin
                    state_d  = S_DONE;
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    if (is_load_q) begin
                        ld_data_d = rd_ext;
                    end
                end else if ((MAX_WAIT != 0) && (cnt_d == MAX_WAIT_W)) begin
                    state_d  = S_DONE;
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    err_d    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            rd_q      <= 5'd0;
            wdata_q   <= 32'd0;
            mask_q    <= 4'd0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            cnt_q     <= 16'd0;
            ld_data_q <= 32'd0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef MSRV32_MISALIGN_TRAP_EN
            misal_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            rd_q      <= rd_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            is_load_q <= is_load_d;
            err_q     <= err_d;
`ifdef MSRV32_MISALIGN_TRAP_EN
            misal_q   <= misal_d;
`endif
        end
    end

    // Output decode: bus side comes straight from registers, pulses only in DONE
    always_comb begin
        dbus_addr_out    = {addr_q[31:2], 2'b00};
        dbus_wdata_out   = wdata_q;
        dbus_wr_mask_out = mask_q;
        dbus_rd_req_out  = rd_req_q;
        dbus_wr_req_out  = wr_req_q;
        ld_data_out      = ld_data_q;
        rd_addr_out      = rd_q;
        bus_err_out      = (state_q == S_DONE) && err_q;
`ifdef MSRV32_MISALIGN_TRAP_EN
        misaligned_out   = (state_q == S_DONE) && misal_q;
        ld_valid_out     = (state_q == S_DONE) && is_load_q && !err_q && !misal_q;
`else
        misaligned_out   = 1'b0;
        ld_valid_out     = (state_q == S_DONE) && is_load_q && !err_q;
`endif
        case (state_q)
            S_IDLE:  stall_out = ld_req_in || st_req_in;
            S_WAIT:  stall_out = 1'b1;
            default: stall_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// tb/tb_msrv32_lsu_ctrl.sv - directed self-checking bench for msrv32_lsu_ctrl
module tb_msrv32_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_req = 1'b0;
    logic        st_req = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_mask;
    logic        dbus_rd_req;
    logic        dbus_wr_req;
    logic [31:0] dbus_rdata = 32'd0;
    logic        dbus_ack = 1'b0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic [4:0]  rd_out;
    logic        bus_err;
    logic        misaligned;

    int checks = 0;
    int failures = 0;

    msrv32_lsu_ctrl #(.MAX_WAIT(4)) dut (
        .clk_in           (clk),
        .reset_in         (reset),
        .ld_req_in        (ld_req),
        .st_req_in        (st_req),
        .load_size_in     (size),
        .load_unsigned_in (uns),
        .addr_in          (addr),
        .st_data_in       (st_data),
        .rd_addr_in       (rd_in),
        .dbus_addr_out    (dbus_addr),
        .dbus_wdata_out   (dbus_wdata),
        .dbus_wr_mask_out (dbus_mask),
        .dbus_rd_req_out  (dbus_rd_req),
        .dbus_wr_req_out  (dbus_wr_req),
        .dbus_rdata_in    (dbus_rdata),
        .dbus_ack_in      (dbus_ack),
        .stall_out        (stall),
        .ld_data_out      (ld_data),
        .ld_valid_out     (ld_valid),
        .rd_addr_out      (rd_out),
        .bus_err_out      (bus_err),
        .misaligned_out   (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Drives a one-cycle request (cycle 0) and returns early in cycle 1, before its sample point
    task automatic start_req(input logic st, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        step();
        st_req  = st;
        ld_req  = !st;
        size    = sz;
        uns     = u;
        addr    = a;
        st_data = d;
        rd_in   = rd;
        sample();
        check("req_stall", {31'd0, stall}, 32'd1);
        step();
        ld_req = 1'b0;
        st_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        reset = 1'b0;
        sample();
        check("rst_rd_req", {31'd0, dbus_rd_req}, 32'd0);
        check("rst_wr_req", {31'd0, dbus_wr_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
        check("rst_addr", dbus_addr, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);

        // LB 0x103, ack in cycle 2 -> ld_valid in cycle 3, sign-extended 0x80
        start_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 5'd7);
        sample();
        check("lb_rd_req", {31'd0, dbus_rd_req}, 32'd1);
        check("lb_wr_req", {31'd0, dbus_wr_req}, 32'd0);
        check("lb_addr", dbus_addr, 32'h0000_0100);
        check("lb_mask", {28'd0, dbus_mask}, 32'd0);
        check("lb_stall_wait", {31'd0, stall}, 32'd1);
        step();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h8000_0000;
        sample();
        check("lb_valid_early", {31'd0, ld_valid}, 32'd0);
        check("lb_rd_req_ack", {31'd0, dbus_rd_req}, 32'd1);
        step();
        dbus_ack = 1'b0;
        sample();
        check("lb_valid", {31'd0, ld_valid}, 32'd1);
        check("lb_data", ld_data, 32'hFFFF_FF80);
        check("lb_rd_addr", {27'd0, rd_out}, 32'd7);
        check("lb_rd_req_drop", {31'd0, dbus_rd_req}, 32'd0);
        check("lb_stall_done", {31'd0, stall}, 32'd0);
        step();
        sample();
        check("lb_valid_pulse", {31'd0, ld_valid}, 32'd0);

        // LHU 0x102, ack in cycle 1 held for three cycles -> one ld_valid only
        start_req(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'd0, 5'd12);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hBEEF_1234;
        sample();
        check("lhu_rd_req", {31'd0, dbus_rd_req}, 32'd1);
        step();
        sample();
        check("lhu_valid", {31'd0, ld_valid}, 32'd1);
        check("lhu_data", ld_data, 32'h0000_BEEF);
        check("lhu_rd_addr", {27'd0, rd_out}, 32'd12);
        step();
        sample();
        check("lhu_ack_once", {31'd0, ld_valid}, 32'd0);
        check("lhu_req_idle", {31'd0, dbus_rd_req}, 32'd0);
        step();
        dbus_ack = 1'b0;
        sample();
        check("lhu_ack_once2", {31'd0, ld_valid}, 32'd0);

        // SB 0x201, a load request in WAIT must be ignored
        start_req(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00A5, 5'd0);
        ld_req = 1'b1;
        sample();
        check("sb_wr_req", {31'd0, dbus_wr_req}, 32'd1);
        check("sb_rd_req", {31'd0, dbus_rd_req}, 32'd0);
        check("sb_mask", {28'd0, dbus_mask}, 32'h2);
        check("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
        check("sb_addr", dbus_addr, 32'h0000_0200);
        step();
        ld_req   = 1'b0;
        dbus_ack = 1'b1;
        sample();
        check("sb_wr_req_ack", {31'd0, dbus_wr_req}, 32'd1);
        step();
        dbus_ack = 1'b0;
        sample();
        check("sb_wr_drop", {31'd0, dbus_wr_req}, 32'd0);
        check("sb_no_valid", {31'd0, ld_valid}, 32'd0);
        check("sb_stall_done", {31'd0, stall}, 32'd0);
        step();
        sample();
        check("sb_no_reissue", {31'd0, dbus_rd_req}, 32'd0);

        // SH 0x202 -> upper half lanes
        start_req(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd0);
        sample();
        check("sh_mask", {28'd0, dbus_mask}, 32'hC);
        check("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
        step();
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;

        // LW with no ack: four WAIT cycles then a bus_err pulse
        start_req(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 5'd9);
        for (int i = 1; i <= 4; i++) begin
            sample();
            check("to_rd_req_wait", {31'd0, dbus_rd_req}, 32'd1);
            check("to_no_err_wait", {31'd0, bus_err}, 32'd0);
            step();
        end
        sample();
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        check("to_no_valid", {31'd0, ld_valid}, 32'd0);
        check("to_rd_req_drop", {31'd0, dbus_rd_req}, 32'd0);
        check("to_stall_rel", {31'd0, stall}, 32'd0);
        step();
        sample();
        check("to_err_pulse", {31'd0, bus_err}, 32'd0);

        // LW 0x102: trap with the macro, normal read of 0x100 without
        start_req(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'd0, 5'd4);
        sample();
`ifdef MSRV32_MISALIGN_TRAP_EN
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        check("mis_no_req", {31'd0, dbus_rd_req}, 32'd0);
        check("mis_stall", {31'd0, stall}, 32'd0);
        check("mis_no_valid", {31'd0, ld_valid}, 32'd0);
        step();
        sample();
        check("mis_pulse_end", {31'd0, misaligned}, 32'd0);
`else
        check("mis_rd_req", {31'd0, dbus_rd_req}, 32'd1);
        check("mis_addr", dbus_addr, 32'h0000_0100);
        check("mis_tied", {31'd0, misaligned}, 32'd0);
        step();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hCAFE_F00D;
        step();
        dbus_ack = 1'b0;
        sample();
        check("mis_valid", {31'd0, ld_valid}, 32'd1);
        check("mis_data", ld_data, 32'hCAFE_F00D);
        check("mis_tied_done", {31'd0, misaligned}, 32'd0);
        step();
`endif

        // Reset asserted in WAIT aborts the access; a later ack is ignored
        start_req(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0, 5'd3);
        sample();
        check("rw_rd_req", {31'd0, dbus_rd_req}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sample();
        check("rw_rd_req_rst", {31'd0, dbus_rd_req}, 32'd0);
        check("rw_addr_rst", dbus_addr, 32'd0);
        check("rw_ld_data_rst", ld_data, 32'd0);
        check("rw_rd_addr_rst", {27'd0, rd_out}, 32'd0);
        check("rw_stall_rst", {31'd0, stall}, 32'd0);
        step();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h1111_2222;
        sample();
        check("rw_ack_ign", {31'd0, ld_valid}, 32'd0);
        step();
        dbus_ack = 1'b0;
        sample();
        check("rw_ack_ign2", {31'd0, ld_valid}, 32'd0);
        check("rw_ld_data_keep", ld_data, 32'd0);
        check("rw_no_req", {31'd0, dbus_rd_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
